// File: rtl/spi_module_pkg.sv
// Shared frame geometry and helpers for the SPI slave bridge.
package spi_module_pkg;

    localparam int CMD_W       = 8;
    localparam int DATA_W      = 32;
    localparam int FRAME_LEN   = CMD_W + DATA_W;
    localparam int CMD_SEL_BIT = 0;
    localparam int CNT_W       = 6;

    // Bit-counter landmarks, pre-sized to the counter width
    localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] CNT_CMD_DONE   = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FRAME_DONE = CNT_W'(FRAME_LEN);

    // Pick register 1 when the select bit is set, else register 0
    function automatic logic [DATA_W-1:0] sel_reg(input logic             sel,
                                                  input logic [DATA_W-1:0] r0,
                                                  input logic [DATA_W-1:0] r1);
        return sel ? r1 : r0;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser with rise/fall detection on the synchronised level.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the asynchronous input through the chain; keep one extra stage for edges
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_module.sv
// SPI slave (mode 0, MSB first): 8-bit command + 32-bit data writes one of two registers.
// MISO returns the previous command as a status byte, then (with SPI_READBACK_EN defined)
// the previous contents of the addressed register; otherwise zeros in the data phase.
module spi_module
    import spi_module_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ncs,
    output logic              miso,
    output logic [CMD_W-1:0]  q_c,
    output logic [DATA_W-1:0] q_0,
    output logic [DATA_W-1:0] q_1
);

    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic unused_edges;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .nrst  (nrst),
        .din   (sck),
        .level (sck_s),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .nrst  (nrst),
        .din   (mosi),
        .level (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    // ncs idles high, so its synchroniser resets high to avoid a false select edge
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk   (clk),
        .nrst  (nrst),
        .din   (ncs),
        .level (ncs_s),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    assign unused_edges = ^{sck_s, mosi_rise, mosi_fall, ncs_rise};

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] rx_q, rx_d, rx_next;
    logic [DATA_W-1:0]    tx_q, tx_d;
    logic                 miso_q, miso_d;
    logic [CMD_W-1:0]     q_c_q, q_c_d;
    logic [DATA_W-1:0]    q_0_q, q_0_d;
    logic [DATA_W-1:0]    q_1_q, q_1_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [DATA_W-1:0]    rd_word;

    assign rx_next = {rx_q[FRAME_LEN-2:0], mosi_s};

`ifdef SPI_READBACK_EN
    assign rd_word = sel_reg(rx_next[CMD_SEL_BIT], q_0_q, q_1_q);
`else
    assign rd_word = '0;
`endif

    // Frame sequencing: select, sample on sck rise, shift out on sck fall, deferred write
    always_comb begin
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        q_c_d     = q_c_q;
        q_0_d     = q_0_q;
        q_1_d     = q_1_q;
        wr_pend_d = 1'b0;

        // Write lands one clk after the last data bit is sampled
        if (wr_pend_q) begin
            if (rx_q[DATA_W+CMD_SEL_BIT]) begin
                q_1_d = rx_q[DATA_W-1:0];
            end else begin
                q_0_d = rx_q[DATA_W-1:0];
            end
        end

        if (ncs_s) begin
            cnt_d  = '0;
            miso_d = 1'b0;
        end else if (ncs_fall) begin
            cnt_d  = '0;
            tx_d   = {q_c_q, {(DATA_W-CMD_W){1'b0}}};
            miso_d = q_c_q[CMD_W-1];
        end else if (sck_rise && (cnt_q < CNT_FRAME_DONE)) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_CMD_LAST) begin
                q_c_d  = rx_next[CMD_W-1:0];
                tx_d   = rd_word;
                miso_d = rd_word[DATA_W-1];
            end
            if (cnt_q == CNT_FRAME_LAST) begin
                wr_pend_d = 1'b1;
            end
        end else if (sck_fall && (cnt_q != '0)) begin
            if (cnt_q >= CNT_FRAME_DONE) begin
                miso_d = 1'b0;
            end else if (cnt_q != CNT_CMD_DONE) begin
                // Data MSB was already presented at rise #8, so fall #8 holds it
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                miso_d = tx_q[DATA_W-2];
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            q_c_q     <= '0;
            q_0_q     <= '0;
            q_1_q     <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            q_c_q     <= q_c_d;
            q_0_q     <= q_0_d;
            q_1_q     <= q_1_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    assign miso = miso_q;
    assign q_c  = q_c_q;
    assign q_0  = q_0_q;
    assign q_1  = q_1_q;

endmodule

// File: tb/tb_spi_module.sv
// Directed bench for spi_module: full, truncated, over-long and reset-aborted frames.
module tb_spi_module;

    localparam int HALF = 137;

`ifdef SPI_READBACK_EN
    localparam logic [31:0] RB_S3 = 32'h24af55aa;
`else
    localparam logic [31:0] RB_S3 = 32'h00000000;
`endif

    logic        clk  = 1'b0;
    logic        nrst = 1'b0;
    logic        sck  = 1'b0;
    logic        mosi = 1'b0;
    logic        ncs  = 1'b1;
    logic        miso;
    logic [7:0]  q_c;
    logic [31:0] q_0;
    logic [31:0] q_1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0]  st;
    logic [31:0] rd;
    int          extra;

    spi_module #(.SYNC_STAGES(2)) dut (
        .clk  (clk),
        .nrst (nrst),
        .sck  (sck),
        .mosi (mosi),
        .ncs  (ncs),
        .miso (miso),
        .q_c  (q_c),
        .q_0  (q_0),
        .q_1  (q_1)
    );

    always #5 clk = ~clk;

    // Drive one frame of nbits; miso is sampled just before each sck rise
    task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                             output logic [7:0] st_o, output logic [31:0] rd_o,
                             output int extra_o);
        logic [39:0] word;
        word    = {cmd, data};
        st_o    = '0;
        rd_o    = '0;
        extra_o = 0;
        ncs     = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 40) ? word[39-i] : 1'b1;
            #HALF;
            if (i < 8) st_o[7-i] = miso;
            else if (i < 40) rd_o[39-i] = miso;
            else extra_o += int'(miso);
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        #HALF;
        ncs  = 1'b1;
        mosi = 1'b0;
        #200;
    endtask

    task automatic test_reset();
        #12;
        total_cnt++;
        if (q_c !== 8'h00) $display("FAIL reset_q_c: got %h want 00", q_c);
        else pass_cnt++;
        total_cnt++;
        if (q_0 !== 32'h0) $display("FAIL reset_q_0: got %h want 00000000", q_0);
        else pass_cnt++;
        total_cnt++;
        if (q_1 !== 32'h0) $display("FAIL reset_q_1: got %h want 00000000", q_1);
        else pass_cnt++;
        total_cnt++;
        if (miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", miso);
        else pass_cnt++;
        #11;
        nrst = 1'b1;
        #50;
    endtask

    task automatic test_first_write();
        spi_frame(8'ha0, 32'h24af55aa, 40, st, rd, extra);
        total_cnt++;
        if (q_c !== 8'ha0) $display("FAIL s1_q_c: got %h want a0", q_c);
        else pass_cnt++;
        total_cnt++;
        if (q_0 !== 32'h24af55aa) $display("FAIL s1_q_0: got %h want 24af55aa", q_0);
        else pass_cnt++;
        total_cnt++;
        if (q_1 !== 32'h0) $display("FAIL s1_q_1: got %h want 00000000", q_1);
        else pass_cnt++;
        total_cnt++;
        if (st !== 8'h00) $display("FAIL s1_status: got %h want 00", st);
        else pass_cnt++;
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL s1_rdata: got %h want 00000000", rd);
        else pass_cnt++;
    endtask

    task automatic test_reg1_write();
        spi_frame(8'h51, 32'h01234567, 40, st, rd, extra);
        total_cnt++;
        if (q_c !== 8'h51) $display("FAIL s2_q_c: got %h want 51", q_c);
        else pass_cnt++;
        total_cnt++;
        if (q_1 !== 32'h01234567) $display("FAIL s2_q_1: got %h want 01234567", q_1);
        else pass_cnt++;
        total_cnt++;
        if (q_0 !== 32'h24af55aa) $display("FAIL s2_q_0: got %h want 24af55aa", q_0);
        else pass_cnt++;
        total_cnt++;
        if (st !== 8'ha0) $display("FAIL s2_status: got %h want a0", st);
        else pass_cnt++;
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL s2_rdata: got %h want 00000000", rd);
        else pass_cnt++;
    endtask

    task automatic test_readback();
        spi_frame(8'ha0, 32'hdeadbeef, 40, st, rd, extra);
        total_cnt++;
        if (st !== 8'h51) $display("FAIL s3_status: got %h want 51", st);
        else pass_cnt++;
        total_cnt++;
        if (rd !== RB_S3) $display("FAIL s3_rdata: got %h want %h", rd, RB_S3);
        else pass_cnt++;
        total_cnt++;
        if (q_0 !== 32'hdeadbeef) $display("FAIL s3_q_0: got %h want deadbeef", q_0);
        else pass_cnt++;
        total_cnt++;
        if (q_c !== 8'ha0) $display("FAIL s3_q_c: got %h want a0", q_c);
        else pass_cnt++;
        total_cnt++;
        if (q_1 !== 32'h01234567) $display("FAIL s3_q_1: got %h want 01234567", q_1);
        else pass_cnt++;
    endtask

    task automatic test_truncated();
        spi_frame(8'h51, 32'hffff0000, 28, st, rd, extra);
        total_cnt++;
        if (q_c !== 8'h51) $display("FAIL s4_q_c: got %h want 51", q_c);
        else pass_cnt++;
        total_cnt++;
        if (q_1 !== 32'h01234567) $display("FAIL s4_q_1: got %h want 01234567", q_1);
        else pass_cnt++;
        total_cnt++;
        if (q_0 !== 32'hdeadbeef) $display("FAIL s4_q_0: got %h want deadbeef", q_0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] word;
        word = {8'h51, 32'hffffffff};
        ncs  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            mosi = word[39-i];
            #HALF;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        #40;
        nrst = 1'b0;
        #22;
        total_cnt++;
        if (q_c !== 8'h00) $display("FAIL s5_q_c: got %h want 00", q_c);
        else pass_cnt++;
        total_cnt++;
        if (q_0 !== 32'h0) $display("FAIL s5_q_0: got %h want 00000000", q_0);
        else pass_cnt++;
        total_cnt++;
        if (q_1 !== 32'h0) $display("FAIL s5_q_1: got %h want 00000000", q_1);
        else pass_cnt++;
        total_cnt++;
        if (miso !== 1'b0) $display("FAIL s5_miso: got %b want 0", miso);
        else pass_cnt++;
        nrst = 1'b1;
        #HALF;
        ncs  = 1'b1;
        mosi = 1'b0;
        #200;
        spi_frame(8'ha0, 32'h24af55aa, 40, st, rd, extra);
        total_cnt++;
        if (q_c !== 8'ha0) $display("FAIL s5r_q_c: got %h want a0", q_c);
        else pass_cnt++;
        total_cnt++;
        if (q_0 !== 32'h24af55aa) $display("FAIL s5r_q_0: got %h want 24af55aa", q_0);
        else pass_cnt++;
        total_cnt++;
        if (q_1 !== 32'h0) $display("FAIL s5r_q_1: got %h want 00000000", q_1);
        else pass_cnt++;
        total_cnt++;
        if (st !== 8'h00) $display("FAIL s5r_status: got %h want 00", st);
        else pass_cnt++;
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL s5r_rdata: got %h want 00000000", rd);
        else pass_cnt++;
    endtask

    task automatic test_extra_bits();
        spi_frame(8'h51, 32'hcafef00d, 44, st, rd, extra);
        total_cnt++;
        if (q_1 !== 32'hcafef00d) $display("FAIL x_q_1: got %h want cafef00d", q_1);
        else pass_cnt++;
        total_cnt++;
        if (q_0 !== 32'h24af55aa) $display("FAIL x_q_0: got %h want 24af55aa", q_0);
        else pass_cnt++;
        total_cnt++;
        if (q_c !== 8'h51) $display("FAIL x_q_c: got %h want 51", q_c);
        else pass_cnt++;
        total_cnt++;
        if (st !== 8'ha0) $display("FAIL x_status: got %h want a0", st);
        else pass_cnt++;
        total_cnt++;
        if (extra !== 0) $display("FAIL x_extra_miso: got %0d ones want 0", extra);
        else pass_cnt++;
        total_cnt++;
        if (miso !== 1'b0) $display("FAIL x_idle_miso: got %b want 0", miso);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_reg1_write();
        test_readback();
        test_truncated();
        test_reset_mid_frame();
        test_extra_bits();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
